// File: rtl/id_ex_if.sv
// ID/EX pipeline register bundle: ID-side request fields driven into the
// register and the registered EX-side view plus hazard/bubble status.
interface id_ex_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  // ID-stage side
  logic              ID_Valid;
  logic              ID_Stall;
  logic              ID_Flush;
  logic [31:0]       IF_ID_rs_FMux_o;
  logic [31:0]       IF_ID_rt_FMux_o;
  logic [31:0]       IF_ID_PCPlusBy4;
  logic [31:0]       IF_ID_Imm_Ext;
  logic [4:0]        IF_ID_rs;
  logic [4:0]        IF_ID_rt;
  logic [4:0]        IF_ID_rd;
  logic [CTRL_W-1:0] IF_ID_Ctrl;

  // EX-stage side
  logic [31:0]       ID_EX_rs_Data;
  logic [31:0]       ID_EX_rt_Data;
  logic [31:0]       ID_EX_PCPlusBy4;
  logic [31:0]       ID_EX_Imm;
  logic [4:0]        ID_EX_rs;
  logic [4:0]        ID_EX_rt;
  logic [4:0]        ID_EX_rd;
  logic [CTRL_W-1:0] ID_EX_Ctrl;
  logic              ID_EX_Valid;
  logic              ID_EX_LoadUse;
  logic [CNT_W-1:0]  ID_EX_BubbleCnt;

  // Pipeline control / ID stage drives the request, reads the EX view.
  modport master (
    output ID_Valid, ID_Stall, ID_Flush,
    output IF_ID_rs_FMux_o, IF_ID_rt_FMux_o, IF_ID_PCPlusBy4, IF_ID_Imm_Ext,
    output IF_ID_rs, IF_ID_rt, IF_ID_rd, IF_ID_Ctrl,
    input  ID_EX_rs_Data, ID_EX_rt_Data, ID_EX_PCPlusBy4, ID_EX_Imm,
    input  ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_Ctrl,
    input  ID_EX_Valid, ID_EX_LoadUse, ID_EX_BubbleCnt
  );

  // The ID/EX register itself.
  modport slave (
    input  ID_Valid, ID_Stall, ID_Flush,
    input  IF_ID_rs_FMux_o, IF_ID_rt_FMux_o, IF_ID_PCPlusBy4, IF_ID_Imm_Ext,
    input  IF_ID_rs, IF_ID_rt, IF_ID_rd, IF_ID_Ctrl,
    output ID_EX_rs_Data, ID_EX_rt_Data, ID_EX_PCPlusBy4, ID_EX_Imm,
    output ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_Ctrl,
    output ID_EX_Valid, ID_EX_LoadUse, ID_EX_BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// stall hold, flush squash and a saturating bubble counter.
// Action priority each edge: reset > flush > stall > load-use bubble > load.
module id_ex_reg #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  logic [31:0]       rs_data_r;
  logic [31:0]       rt_data_r;
  logic [31:0]       pc4_r;
  logic [31:0]       imm_r;
  logic [4:0]        rs_r;
  logic [4:0]        rt_r;
  logic [4:0]        rd_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic              valid_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              load_use_s;
  logic              bubble_s;
  logic              hold_s;
  logic              cnt_inc_s;

  // Hazard detection and per-edge action selection (flush wins over stall).
  always_comb begin
    load_use_s = valid_r & ctrl_r[1] & (rt_r != 5'd0) & bus.ID_Valid &
                 ((rt_r == bus.IF_ID_rs) | (rt_r == bus.IF_ID_rt));
    bubble_s   = 1'b0;
    hold_s     = 1'b0;
    if (bus.ID_Flush) begin
      bubble_s = 1'b1;
    end else if (bus.ID_Stall) begin
      hold_s = 1'b1;
    end else if (load_use_s) begin
      bubble_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
    end
    // Only a squashed real instruction counts, and the counter never wraps.
    cnt_inc_s = bubble_s & bus.ID_Valid & (cnt_r != {CNT_W{1'b1}});
  end

  // Pipeline register: hold on stall, zero control/valid on bubble, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_r <= 32'd0;
      rt_data_r <= 32'd0;
      pc4_r     <= 32'd0;
      imm_r     <= 32'd0;
      rs_r      <= 5'd0;
      rt_r      <= 5'd0;
      rd_r      <= 5'd0;
      ctrl_r    <= {CTRL_W{1'b0}};
      valid_r   <= 1'b0;
    end else if (!hold_s) begin
      rs_data_r <= bus.IF_ID_rs_FMux_o;
      rt_data_r <= bus.IF_ID_rt_FMux_o;
      pc4_r     <= bus.IF_ID_PCPlusBy4;
      imm_r     <= bus.IF_ID_Imm_Ext;
      rs_r      <= bus.IF_ID_rs;
      rt_r      <= bus.IF_ID_rt;
      rd_r      <= bus.IF_ID_rd;
      ctrl_r    <= bubble_s ? {CTRL_W{1'b0}} : bus.IF_ID_Ctrl;
      valid_r   <= bubble_s ? 1'b0 : bus.ID_Valid;
    end
  end

  // Saturating count of squashed real instructions since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.ID_EX_rs_Data   = rs_data_r;
  assign bus.ID_EX_rt_Data   = rt_data_r;
  assign bus.ID_EX_PCPlusBy4 = pc4_r;
  assign bus.ID_EX_Imm       = imm_r;
  assign bus.ID_EX_rs        = rs_r;
  assign bus.ID_EX_rt        = rt_r;
  assign bus.ID_EX_rd        = rd_r;
  assign bus.ID_EX_Ctrl      = ctrl_r;
  assign bus.ID_EX_Valid     = valid_r;
  assign bus.ID_EX_LoadUse   = load_use_s;
  assign bus.ID_EX_BubbleCnt = cnt_r;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_id_ex_reg;
  localparam int CW   = 16;
  localparam int NW   = 4;
  localparam int CMAX = (1 << NW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_if #(.CTRL_W(CW), .CNT_W(NW)) bus();
  id_ex_reg #(.CTRL_W(CW), .CNT_W(NW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model of the EX-side contents
  bit          m_valid;
  logic [31:0] m_rsd, m_rtd, m_pc, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;
  int          m_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    return m_valid && m_ctrl[1] && (m_rt != 5'd0) && bus.ID_Valid &&
           ((m_rt == bus.IF_ID_rs) || (m_rt == bus.IF_ID_rt));
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rsd = 32'd0; m_rtd = 32'd0; m_pc = 32'd0; m_imm = 32'd0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_ctrl = '0; m_cnt = 0;
  endtask

  task automatic model_squash();
    if (bus.ID_Valid && m_cnt < CMAX) m_cnt++;
    m_valid = 1'b0;
    m_ctrl  = '0;
  endtask

  // Apply one clock edge's worth of behaviour to the model (inputs pre-edge).
  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (bus.ID_Flush) model_squash();
    else if (bus.ID_Stall) begin end
    else if (model_hazard()) model_squash();
    else begin
      m_valid = bus.ID_Valid;
      m_rsd = bus.IF_ID_rs_FMux_o; m_rtd = bus.IF_ID_rt_FMux_o;
      m_pc  = bus.IF_ID_PCPlusBy4; m_imm = bus.IF_ID_Imm_Ext;
      m_rs  = bus.IF_ID_rs; m_rt = bus.IF_ID_rt; m_rd = bus.IF_ID_rd;
      m_ctrl = bus.IF_ID_Ctrl;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit v, input bit s, input bit f,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [CW-1:0] ctrl);
    bus.ID_Valid = v; bus.ID_Stall = s; bus.ID_Flush = f;
    bus.IF_ID_rs = rs; bus.IF_ID_rt = rt; bus.IF_ID_rd = rd;
    bus.IF_ID_rs_FMux_o = rsd; bus.IF_ID_rt_FMux_o = rtd;
    bus.IF_ID_PCPlusBy4 = pc; bus.IF_ID_Imm_Ext = imm; bus.IF_ID_Ctrl = ctrl;
  endtask

  task automatic rand_in(input bit stall_only);
    logic [CW-1:0] c;
    c = CW'($urandom);
    c[1] = ($urandom_range(0, 1) == 0);
    set_in($urandom_range(0, 9) != 0,
           stall_only ? 1'b1 : ($urandom_range(0, 4) == 0),
           stall_only ? 1'b0 : ($urandom_range(0, 9) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
           $urandom, $urandom, $urandom, $urandom, c);
  endtask

  // Per-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",   64'(bus.ID_EX_Valid),     64'(m_valid));
      check("ctrl",    64'(bus.ID_EX_Ctrl),      64'(m_ctrl));
      check("bubbles", 64'(bus.ID_EX_BubbleCnt), 64'(m_cnt));
      check("loaduse", 64'(bus.ID_EX_LoadUse),   64'(model_hazard()));
      if (m_valid) begin
        check("rs_data", 64'(bus.ID_EX_rs_Data),   64'(m_rsd));
        check("rt_data", 64'(bus.ID_EX_rt_Data),   64'(m_rtd));
        check("pc4",     64'(bus.ID_EX_PCPlusBy4), 64'(m_pc));
        check("imm",     64'(bus.ID_EX_Imm),       64'(m_imm));
        check("rs",      64'(bus.ID_EX_rs),        64'(m_rs));
        check("rt",      64'(bus.ID_EX_rt),        64'(m_rt));
        check("rd",      64'(bus.ID_EX_rd),        64'(m_rd));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   64'(bus.ID_EX_Valid),     64'd0);
    check({tag, "_ctrl"},    64'(bus.ID_EX_Ctrl),      64'd0);
    check({tag, "_rs_data"}, 64'(bus.ID_EX_rs_Data),   64'd0);
    check({tag, "_rt_data"}, 64'(bus.ID_EX_rt_Data),   64'd0);
    check({tag, "_pc4"},     64'(bus.ID_EX_PCPlusBy4), 64'd0);
    check({tag, "_imm"},     64'(bus.ID_EX_Imm),       64'd0);
    check({tag, "_rt"},      64'(bus.ID_EX_rt),        64'd0);
    check({tag, "_cnt"},     64'(bus.ID_EX_BubbleCnt), 64'd0);
    check({tag, "_loaduse"}, 64'(bus.ID_EX_LoadUse),   64'd0);
  endtask

  task automatic at_check_point();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'h0000);
    model_reset();
    #3;
    check_all_zero("reset");
    #9;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Pass-through
    set_in(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h1111_0000, 32'hDEAD_BEEF,
           32'h0000_0104, 32'hFFFF_FFF0, 16'h0001);
    cyc();
    at_check_point();
    check("pass_rt_data", 64'(bus.ID_EX_rt_Data), 64'hDEAD_BEEF);
    check("pass_ctrl",    64'(bus.ID_EX_Ctrl),    64'h0001);
    check("pass_valid",   64'(bus.ID_EX_Valid),   64'd1);

    // Load-use: lw rt=5 in EX, consumer rs=5 in ID
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 32'h108, 32'd4, 16'h0003);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 5'd5, 5'd7, 5'd9, 32'hA5A5_0001, 32'h5A5A_0002,
           32'h10C, 32'd8, 16'h0001);
    at_check_point();
    check("lu_flag", 64'(bus.ID_EX_LoadUse), 64'd1);
    cyc();
    at_check_point();
    check("lu_bubble_ctrl",  64'(bus.ID_EX_Ctrl),      64'd0);
    check("lu_bubble_valid", 64'(bus.ID_EX_Valid),     64'd0);
    check("lu_bubble_cnt",   64'(bus.ID_EX_BubbleCnt), 64'd1);
    cyc();
    at_check_point();
    check("lu_reload_valid", 64'(bus.ID_EX_Valid),   64'd1);
    check("lu_reload_rs",    64'(bus.ID_EX_rs_Data), 64'hA5A5_0001);
    check("lu_reload_ctrl",  64'(bus.ID_EX_Ctrl),    64'h0001);

    // Stall hold for three edges with changing inputs
    set_in(1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd6, 32'h1234_5678, 32'h0, 32'h110, 32'd0, 16'h0001);
    cyc();
    for (int i = 0; i < 3; i++) begin
      rand_in(1'b1);
      cyc();
    end
    at_check_point();
    check("stall_rs_data", 64'(bus.ID_EX_rs_Data),   64'h1234_5678);
    check("stall_cnt",     64'(bus.ID_EX_BubbleCnt), 64'd1);

    // Flush beats stall
    set_in(1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 32'd1, 32'd1, 32'd1, 32'd1, 16'h0007);
    cyc();
    at_check_point();
    check("flush_valid", 64'(bus.ID_EX_Valid),     64'd0);
    check("flush_ctrl",  64'(bus.ID_EX_Ctrl),      64'd0);
    check("flush_cnt",   64'(bus.ID_EX_BubbleCnt), 64'd2);

    // Load with rt=0 never triggers a hazard
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h200, 32'd0, 16'h0003);
    cyc();
    set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 32'h55, 32'h66, 32'h204, 32'd0, 16'h0001);
    at_check_point();
    check("zero_reg_lu", 64'(bus.ID_EX_LoadUse), 64'd0);
    cyc();
    at_check_point();
    check("zero_reg_valid", 64'(bus.ID_EX_Valid),   64'd1);
    check("zero_reg_rs",    64'(bus.ID_EX_rs_Data), 64'h55);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_in(1'b0);
      cyc();
    end

    // Async reset mid-stall; first edge after release performs a normal load
    set_in(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 32'hCAFE, 32'hF00D, 32'h300, 32'd1, 16'h0001);
    cyc();
    set_in(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'hBEEF_0001, 32'h2, 32'h304, 32'd2, 16'h0001);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.ID_Stall = 1'b0;
    cyc();
    at_check_point();
    check("post_rst_valid", 64'(bus.ID_EX_Valid),   64'd1);
    check("post_rst_rs",    64'(bus.ID_EX_rs_Data), 64'hBEEF_0001);

    // Saturation of the bubble counter via repeated flushes
    set_in(1'b1, 1'b0, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0, 16'h0001);
    for (int i = 0; i < CMAX + 5; i++) cyc();
    at_check_point();
    check("sat_cnt", 64'(bus.ID_EX_BubbleCnt), 64'(CMAX));
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("sat_rst_cnt", 64'(bus.ID_EX_BubbleCnt), 64'd0);
    cyc();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.ID_Flush = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    at_check_point();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
